tlc_req_frontend: RTL and testbench



---
 rtl/tlc_req_frontend.sv | 131 +++++++++++++
 tb/tb_tlc_req_frontend.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_req_frontend.sv
// Synchroniser, debouncer and sticky request/acknowledge stage for the ped and car inputs.
// Optional press statistics are compiled in with `define TLC_REQ_STATS_EN.
module tlc_req_frontend #(
    parameter int DB_CYCLES = 1000,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       ped_raw,
    input  logic       car_raw,
    input  logic       ped_ack,
    input  logic       car_ack,
    output logic       ped_req,
    output logic       car_req,
    output logic [7:0] ped_cnt,
    output logic [7:0] car_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } req_state_e;

    // Channel index 0 is ped, index 1 is car.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 2);

    logic [1:0]       raw;
    logic [1:0]       ack;
    logic [1:0]       press;
    logic [1:0]       req;
    logic [1:0]       s1_q;
    logic [1:0]       s2_q;
    logic [1:0]       db_q;
    logic [1:0]       db_d;
    logic [1:0]       db_dly_q;
    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_d   [2];
    req_state_e       state_q [2];
    req_state_e       state_d [2];

    assign raw = {car_raw, ped_raw};
    assign ack = {car_ack, ped_ack};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]   <= '0;
                state_q[i] <= IDLE;
            end
        end else begin
            s1_q     <= raw;
            s2_q     <= s1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]   <= cnt_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    // cnt counts consecutive s2 samples that disagree with db. s1 is the sample s2
    // loads next, so the final sample is taken from s1 and db lands on edge DB_CYCLES+1.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            db_d[i]  = db_q[i];
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST && s1_q[i] != db_q[i]) begin
                    db_d[i] = s1_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press = db_q & ~db_dly_q & {2{ena}};

    // Acknowledge wins over a coincident press; a press while pending merges.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE:    if (press[i]) state_d[i] = PEND;
                PEND:    if (ack[i])   state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        req = '0;
        for (int i = 0; i < 2; i++) begin
            req[i] = (state_q[i] == PEND);
        end
    end

    assign ped_req = req[0];
    assign car_req = req[1];

`ifdef TLC_REQ_STATS_EN
    logic [7:0] stat_q [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                stat_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (press[i] && stat_q[i] != 8'hFF) begin
                    stat_q[i] <= stat_q[i] + 8'd1;
                end
            end
        end
    end

    assign ped_cnt = stat_q[0];
    assign car_cnt = stat_q[1];
`else
    assign ped_cnt = 8'h00;
    assign car_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_tlc_req_frontend.sv
// Randomised and directed bench for tlc_req_frontend against a window-based request model.
module tb_tlc_req_frontend;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       ped_raw = 1'b0;
  logic       car_raw = 1'b0;
  logic       ped_ack = 1'b0;
  logic       car_ack = 1'b0;
  logic       ped_req;
  logic       car_req;
  logic [7:0] ped_cnt;
  logic [7:0] car_cnt;

  int n_vec = 0;
  int n_err = 0;

  tlc_req_frontend #(
    .DB_CYCLES(DB),
    .CNT_W    (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ped_raw(ped_raw),
    .car_raw(car_raw),
    .ped_ack(ped_ack),
    .car_ack(car_ack),
    .ped_req(ped_req),
    .car_req(car_req),
    .ped_cnt(ped_cnt),
    .car_cnt(car_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: db flips once the last DB synchronised samples all disagree with it
  bit m_db[2];
  bit m_db_prev[2];
  bit m_req[2];
  int m_cnt[2];
  bit hist0[$];
  bit hist1[$];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_db[c] = 1'b0;
      m_db_prev[c] = 1'b0;
      m_req[c] = 1'b0;
      m_cnt[c] = 0;
    end
    hist0.delete();
    hist1.delete();
    for (int k = 0; k < DB; k++) begin
      hist0.push_back(1'b0);
      hist1.push_back(1'b0);
    end
  endtask

  task automatic model_step();
    bit raw[2];
    bit ack[2];
    bit press;
    bit all_diff;
    raw[0] = ped_raw;
    raw[1] = car_raw;
    ack[0] = ped_ack;
    ack[1] = car_ack;
    for (int c = 0; c < 2; c++) begin
      press = m_db[c] && !m_db_prev[c] && ena;
      if (m_req[c]) begin
        if (ack[c]) m_req[c] = 1'b0;
      end else if (press) begin
        m_req[c] = 1'b1;
      end
      if (press && m_cnt[c] < 255) m_cnt[c]++;
      m_db_prev[c] = m_db[c];
      all_diff = 1'b1;
      for (int k = 0; k < DB; k++) begin
        if ((c == 0 ? hist0[k] : hist1[k]) == m_db[c]) all_diff = 1'b0;
      end
      if (all_diff) m_db[c] = !m_db[c];
    end
    hist0.push_back(raw[0]);
    void'(hist0.pop_front());
    hist1.push_back(raw[1]);
    void'(hist1.pop_front());
  endtask

  function automatic logic [7:0] exp_cnt(int c);
`ifdef TLC_REQ_STATS_EN
    return 8'(m_cnt[c]);
`else
    return 8'h00;
`endif
  endfunction

  // scoreboard check
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_ped_req"}, {7'd0, ped_req}, {7'd0, m_req[0]});
    check({tag, "_car_req"}, {7'd0, car_req}, {7'd0, m_req[1]});
    check({tag, "_ped_cnt"}, ped_cnt, exp_cnt(0));
    check({tag, "_car_cnt"}, car_cnt, exp_cnt(1));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ped_req"}, {7'd0, ped_req}, 8'd0);
    check({tag, "_car_req"}, {7'd0, car_req}, 8'd0);
    check({tag, "_ped_cnt"}, ped_cnt, 8'd0);
    check({tag, "_car_cnt"}, car_cnt, 8'd0);
  endtask

  // driver tasks: inputs change on the falling edge, outputs are checked there too
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic ack_pulse(input int c, input string tag);
    if (c == 0) ped_ack = 1'b1; else car_ack = 1'b1;
    tick(tag);
    ped_ack = 1'b0;
    car_ack = 1'b0;
  endtask

  task automatic pulse(input int c, input int len, input int gap, input string tag);
    if (c == 0) ped_raw = 1'b1; else car_raw = 1'b1;
    run(len, tag);
    if (c == 0) ped_raw = 1'b0; else car_raw = 1'b0;
    run(gap, tag);
  endtask

  initial begin
    int hold[2];

    // reset with both raw inputs already high
    model_reset();
    ped_raw = 1'b1;
    car_raw = 1'b1;
    ena = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_zero("in_reset");
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick("release");
      check("release_lat_ped", {7'd0, ped_req}, (i >= 6) ? 8'd1 : 8'd0);
      check("release_lat_car", {7'd0, car_req}, (i >= 6) ? 8'd1 : 8'd0);
    end
    ped_ack = 1'b1;
    car_ack = 1'b1;
    tick("ack_both");
    ped_ack = 1'b0;
    car_ack = 1'b0;
    ped_raw = 1'b0;
    car_raw = 1'b0;
    run(8, "settle");

    // glitch rejection then minimal accepted pulse
    pulse(0, 3, 20, "glitch3");
    check("glitch3_req", {7'd0, ped_req}, 8'd0);
    ped_raw = 1'b1;
    run(4, "pulse4");
    ped_raw = 1'b0;
    run(2, "pulse4");
    check("pulse4_req", {7'd0, ped_req}, 8'd1);
    run(6, "pulse4");
    ack_pulse(0, "pulse4_ack");

    // handshake: ack while raw stays high, then a fresh press
    car_raw = 1'b1;
    run(8, "hs");
    ack_pulse(1, "hs_ack");
    check("hs_drop", {7'd0, car_req}, 8'd0);
    run(10, "hs_hold");
    car_raw = 1'b0;
    run(8, "hs_rel");
    pulse(1, 6, 6, "hs_again");
    check("hs_again_req", {7'd0, car_req}, 8'd1);
    ack_pulse(1, "hs_ack2");

    // merge while pending, collision with ack, ack while idle
    pulse(0, 6, 6, "merge1");
    pulse(0, 6, 6, "merge2");
    check("merge_req", {7'd0, ped_req}, 8'd1);
    ped_raw = 1'b1;
    run(5, "collide");
    ack_pulse(0, "collide_ack");
    check("collide_req", {7'd0, ped_req}, 8'd0);
    ped_raw = 1'b0;
    run(8, "collide");
    ack_pulse(0, "idle_ack");
    check("idle_ack_req", {7'd0, ped_req}, 8'd0);

    // gating
    ena = 1'b0;
    pulse(1, 10, 8, "gated");
    ena = 1'b1;
    check("gated_req", {7'd0, car_req}, 8'd0);

    // saturation
    for (int p = 0; p < 300; p++) begin
      pulse(1, 5, 5, "sat");
      ack_pulse(1, "sat_ack");
    end
`ifdef TLC_REQ_STATS_EN
    check("sat_cnt", car_cnt, 8'd255);
`else
    check("sat_cnt", car_cnt, 8'd0);
`endif

    // random traffic
    hold[0] = 0;
    hold[1] = 0;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold[c] == 0) begin
          hold[c] = $urandom_range(1, 9);
          if (c == 0) ped_raw = 1'($urandom_range(0, 1)); else car_raw = 1'($urandom_range(0, 1));
        end
        hold[c]--;
      end
      ped_ack = ($urandom_range(0, 7) == 0);
      car_ack = ($urandom_range(0, 7) == 0);
      ena = ($urandom_range(0, 9) != 0);
      tick("rand");
    end
    ped_ack = 1'b0;
    car_ack = 1'b0;
    ena = 1'b1;
    ped_raw = 1'b0;
    car_raw = 1'b0;
    run(8, "rand_end");
    ack_pulse(0, "rand_ack");
    ack_pulse(1, "rand_ack");

    // asynchronous reset mid-operation
    ped_raw = 1'b1;
    run(7, "async_pre");
    car_raw = 1'b1;
    run(2, "async_pre");
    check("async_pre_req", {7'd0, ped_req}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_now");
    model_reset();
    @(negedge clk);
    check_zero("async_hold");
    ped_raw = 1'b0;
    car_raw = 1'b0;
    rst_n = 1'b1;
    run(10, "async_post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
